lcd1602_rx: RTL and testbench
=============================

Name: lcd1602_rx

Overview:
- Receiving end of the HD44780-style 8-bit parallel write bus driven by our LCD1602 controllers.
- Samples RS/RW/E/D and decodes the instruction set a 1602 panel honours.
- Keeps a 32-character DDRAM image (2x16) plus display/cursor state, with a read port.
- Used as an on-FPGA display model: lets the LCD writer be checked in-system, and feeds VGA/7-seg mirrors.

Parameters:
- SYNC_STAGES, 2: flop stages on every bus input (RS, RW, E, D).
- BLINK_HALF_PERIOD, 24'd6_000_000: FPGA_CLK cycles per blink phase. Used only with the blink feature.

Ports:
- FPGA_CLK  in  1  system clock.
- RST_N  in  1  synchronous, active-low reset.
- LCD_RS  in  1  register select: 0 = instruction, 1 = data.
- LCD_RW  in  1  0 = write; 1 = read (ignored).
- LCD_E  in  1  enable strobe; a transaction commits on its falling edge.
- LCD_D  in  8  bus data.
- RD_ADDR  in  5  image read index: 0-15 = row 0, 16-31 = row 1.
- RD_DATA  out  8  character at RD_ADDR; registered, 1-cycle latency.
- CURSOR  out  5  image index of the address counter (AC).
- CURSOR_VIS  out  1  AC lies in a visible window.
- CURSOR_SHOW  out  1  cursor glyph to be drawn this cycle.
- DISP_ON, CURSOR_ON, BLINK_ON  out  1 each  display-control flags.
- INC_MODE  out  1  1 = AC increments after a data write.
- INIT_DONE  out  1  sticky; set by function set with DL=1.
- BUSY  out  1  clear sequence running.
- CMD_STB, DATA_STB, OVERRUN  out  1 each  one-cycle pulses.

Behaviour:
- Input sync and commit:
  - All bus inputs pass through SYNC_STAGES flops.
  - Commit = synchronized E 1->0 with synchronized RW=0.
  - RS and D are taken from the same sync stage as E at the commit cycle.
  - Bus must hold RS/D stable at least SYNC_STAGES+2 cycles either side of the E fall.
  - E falls with RW=1 are ignored: no strobe, no state change.
- Commit while BUSY: transaction dropped, OVERRUN pulses next cycle.
- Otherwise CMD_STB (RS=0) or DATA_STB (RS=1) pulses the cycle after commit.
- Instruction decode, by highest set bit of D:
  - 0x01 clear: AC=0, INC_MODE=1, cg_sel=0, BUSY=1. Writes 0x20 to image indices 0..31, one per cycle; BUSY falls after the 32nd write.
  - 0x02/0x03 home: AC=0, cg_sel=0.
  - 0x04-07 entry mode: INC_MODE=D[1]. Shift bit D[0] is ignored.
  - 0x08-0F display control: DISP_ON=D[2], CURSOR_ON=D[1], BLINK_ON=D[0].
  - 0x10-1F shift: if D[3]=0, AC moves by one (D[2]=1 right, 0 left) with the wrap rule below. D[3]=1 (display shift) is ignored.
  - 0x20-3F function set: INIT_DONE<=1 if D[4]=1. Other bits are ignored.
  - 0x40-7F set CGRAM address: cg_sel=1.
  - 0x80-FF set DDRAM address: AC=D[6:0], cg_sel=0.
- Data write:
  - If cg_sel=1, the byte is discarded and AC is unchanged.
  - Otherwise the byte is stored when AC is visible: AC 0x00-0x0F -> index AC; AC 0x40-0x4F -> index AC-0x30.
  - AC then steps +1 (INC_MODE=1) or -1.
- AC wrap (7-bit):
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
  - Out-of-range values loaded by set-DDRAM are held as loaded; the next step uses the same rules.
- CURSOR: mapped index when CURSOR_VIS=1, else 0.
- RD_DATA: reflects any write completed in or before the cycle RD_ADDR is sampled. During a clear it shows partial fill.
- Reset: applies while RST_N=0 at a clock edge.
  - RD_DATA=0x00, DISP_ON=CURSOR_ON=BLINK_ON=0, INC_MODE=1, INIT_DONE=0, AC=0, cg_sel=0.
  - All strobes 0; sync flops cleared (E=0).
  - The first cycle after release starts the clear sequence: BUSY=1 for 32 cycles.
  - Reset mid-clear restarts the sequence from index 0.

Optional Feature:
- LCD1602_RX_BLINK_EN defined:
  - A counter toggles blink_phase every BLINK_HALF_PERIOD cycles; the counter is reset to 0 with phase 0.
  - CURSOR_SHOW = DISP_ON & CURSOR_VIS & (CURSOR_ON | (BLINK_ON & blink_phase)).
- Undefined:
  - No counter.
  - CURSOR_SHOW = DISP_ON & CURSOR_VIS & CURSOR_ON; BLINK_ON is still reported.

Decomposition:
- lcd1602_pkg holds:
  - Opcode bit positions.
  - AC constants 0x27, 0x40, 0x67.
  - Row base 0x40, ROW_LEN 16, IMG_DEPTH 32.
  - Space code 0x20.
  - Decoded-command enum: CLR, HOME, ENTRY, DCTL, SHIFT, FSET, CGADDR, DDADDR.
- Sub-module lcd1602_rx_sync: the SYNC_STAGES synchronizer plus E falling-edge detect, emitting commit, rs, rw, d.

Test Plan:
- Reset -> BUSY high exactly 32 cycles after release; RD_DATA=0x20 for RD_ADDR 0..31; INIT_DONE=0.
- Writes 0x30, 0x0C, 0x06, 0x01, wait for BUSY low, then "HELLO WORLD!" -> indices 0..11 hold the text, index 12 = 0x20, CURSOR=12, DISP_ON=1, CURSOR_ON=0, INIT_DONE=1.
- Cmd 0xA7, data 'A', 'B' -> 'A' not stored (AC 0x27 not visible), 'B' at index 16, CURSOR=17.
- Cmd 0x04, cmd 0x80, data 'X' -> 'X' at index 0, AC=0x67, CURSOR_VIS=0.
- Cmd 0x01, then a data write committed 5 cycles later -> OVERRUN pulses, no DATA_STB, image all 0x20.
- E pulse with RW=1 -> no strobe; cmd 0x40 then data 'Z' -> image unchanged.
- Reset asserted at clear index 10 -> clear restarts from index 0, BUSY=1 for 32 cycles.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared constants, decoded-command type and address-counter helpers for the LCD1602 bus
// receiver.
package lcd1602_pkg;

  // Opcode class is selected by the highest set bit of the instruction byte.
  localparam int unsigned OP_CLR_BIT    = 0;
  localparam int unsigned OP_HOME_BIT   = 1;
  localparam int unsigned OP_ENTRY_BIT  = 2;
  localparam int unsigned OP_DCTL_BIT   = 3;
  localparam int unsigned OP_SHIFT_BIT  = 4;
  localparam int unsigned OP_FSET_BIT   = 5;
  localparam int unsigned OP_CGADDR_BIT = 6;
  localparam int unsigned OP_DDADDR_BIT = 7;

  localparam logic [6:0] AC_ROW0_END = 7'h27;
  localparam logic [6:0] ROW_BASE    = 7'h40;
  localparam logic [6:0] AC_ROW1_END = 7'h67;

  localparam int unsigned ROW_LEN   = 16;
  localparam int unsigned IMG_DEPTH = 32;

  localparam logic [7:0] SPACE_CODE = 8'h20;

  typedef enum logic [3:0] {
    CmdNone,
    CmdClr,
    CmdHome,
    CmdEntry,
    CmdDctl,
    CmdShift,
    CmdFset,
    CmdCgaddr,
    CmdDdaddr
  } cmd_e;

  function automatic cmd_e decode_cmd(logic [7:0] d);
    cmd_e cmd;
    if (d[OP_DDADDR_BIT])      cmd = CmdDdaddr;
    else if (d[OP_CGADDR_BIT]) cmd = CmdCgaddr;
    else if (d[OP_FSET_BIT])   cmd = CmdFset;
    else if (d[OP_SHIFT_BIT])  cmd = CmdShift;
    else if (d[OP_DCTL_BIT])   cmd = CmdDctl;
    else if (d[OP_ENTRY_BIT])  cmd = CmdEntry;
    else if (d[OP_HOME_BIT])   cmd = CmdHome;
    else if (d[OP_CLR_BIT])    cmd = CmdClr;
    else                       cmd = CmdNone;
    return cmd;
  endfunction

  // Row ends jump to the other row's start; other values just count, so out-of-range
  // addresses drift until they hit a wrap point.
  function automatic logic [6:0] ac_step(logic [6:0] ac, logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == AC_ROW0_END)      nxt = ROW_BASE;
      else if (ac == AC_ROW1_END) nxt = 7'h00;
      else                        nxt = ac + 7'd1;
    end else begin
      if (ac == 7'h00)            nxt = AC_ROW1_END;
      else if (ac == ROW_BASE)    nxt = AC_ROW0_END;
      else                        nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  function automatic logic ac_visible(logic [6:0] ac);
    return (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
  endfunction

  function automatic logic [4:0] ac_index(logic [6:0] ac);
    logic [4:0] col;
    col = {1'b0, ac[3:0]};
    return ac[6] ? (5'(ROW_LEN) + col) : col;
  endfunction

endpackage

// File: rtl/lcd1602_rx_sync.sv
// Bus input synchronizer with enable falling-edge detect; commit marks a write
// transaction (E 1->0 with RW low) in the same stage as rs/d.
module lcd1602_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       FPGA_CLK,
  input  logic       RST_N,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic       e_i,
  input  logic [7:0] d_i,
  output logic       commit_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [7:0] d_o
);

  localparam int unsigned Last = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] rs_q;
  logic [SYNC_STAGES-1:0] rw_q;
  logic [SYNC_STAGES-1:0] e_q;
  logic [7:0]             d_q [SYNC_STAGES];
  logic                   e_prev_q;

  always_ff @(posedge FPGA_CLK) begin
    if (!RST_N) begin
      rs_q     <= '0;
      rw_q     <= '0;
      e_q      <= '0;
      e_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) d_q[i] <= 8'h00;
    end else begin
      rs_q[0] <= rs_i;
      rw_q[0] <= rw_i;
      e_q[0]  <= e_i;
      d_q[0]  <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rs_q[i] <= rs_q[i-1];
        rw_q[i] <= rw_q[i-1];
        e_q[i]  <= e_q[i-1];
        d_q[i]  <= d_q[i-1];
      end
      e_prev_q <= e_q[Last];
    end
  end

  assign commit_o = e_prev_q & ~e_q[Last] & ~rw_q[Last];
  assign rs_o     = rs_q[Last];
  assign rw_o     = rw_q[Last];
  assign d_o      = d_q[Last];

endmodule

// File: rtl/lcd1602_rx.sv
// HD44780-style 8-bit write-bus receiver keeping a 2x16 DDRAM image and cursor state.
// Define LCD1602_RX_BLINK_EN to gate the cursor glyph with a blink phase counter.
module lcd1602_rx
  import lcd1602_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter logic [23:0] BLINK_HALF_PERIOD = 24'd6_000_000
) (
  input  logic       FPGA_CLK,
  input  logic       RST_N,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_E,
  input  logic [7:0] LCD_D,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic [4:0] CURSOR,
  output logic       CURSOR_VIS,
  output logic       CURSOR_SHOW,
  output logic       DISP_ON,
  output logic       CURSOR_ON,
  output logic       BLINK_ON,
  output logic       INC_MODE,
  output logic       INIT_DONE,
  output logic       BUSY,
  output logic       CMD_STB,
  output logic       DATA_STB,
  output logic       OVERRUN
);

  localparam logic [4:0] CLR_LAST = 5'(IMG_DEPTH - 1);

  logic       sync_commit;
  logic       sync_rs;
  logic       sync_rw;
  logic [7:0] sync_d;

  lcd1602_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .FPGA_CLK (FPGA_CLK),
    .RST_N    (RST_N),
    .rs_i     (LCD_RS),
    .rw_i     (LCD_RW),
    .e_i      (LCD_E),
    .d_i      (LCD_D),
    .commit_o (sync_commit),
    .rs_o     (sync_rs),
    .rw_o     (sync_rw),
    .d_o      (sync_d)
  );

  // RW is already folded into commit.
  logic unused_rw;
  assign unused_rw = sync_rw;

  logic [6:0] ac_q;
  logic       cg_sel_q;
  logic       inc_mode_q;
  logic       disp_on_q;
  logic       cursor_on_q;
  logic       blink_on_q;
  logic       init_done_q;
  logic       busy_q;
  logic [4:0] clr_idx_q;
  logic       cmd_stb_q;
  logic       data_stb_q;
  logic       overrun_q;
  logic [7:0] rd_data_q;

  logic [7:0] img_q [IMG_DEPTH];
  logic       img_we;
  logic [4:0] img_waddr;
  logic [7:0] img_wdata;

  logic       ac_vis;
  logic [4:0] ac_idx;

  assign ac_vis = ac_visible(ac_q);
  assign ac_idx = ac_index(ac_q);

  // Single write port: the clear sweep owns it while busy, bus data otherwise.
  always_comb begin
    img_we    = 1'b0;
    img_waddr = clr_idx_q;
    img_wdata = SPACE_CODE;
    if (RST_N) begin
      if (busy_q) begin
        img_we = 1'b1;
      end else if (sync_commit && sync_rs && !cg_sel_q && ac_vis) begin
        img_we    = 1'b1;
        img_waddr = ac_idx;
        img_wdata = sync_d;
      end
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (img_we) img_q[img_waddr] <= img_wdata;
  end

  always_ff @(posedge FPGA_CLK) begin
    if (!RST_N) begin
      rd_data_q <= 8'h00;
    end else if (img_we && (img_waddr == RD_ADDR)) begin
      rd_data_q <= img_wdata;
    end else begin
      rd_data_q <= img_q[RD_ADDR];
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (!RST_N) begin
      ac_q        <= 7'h00;
      cg_sel_q    <= 1'b0;
      inc_mode_q  <= 1'b1;
      disp_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
      blink_on_q  <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      clr_idx_q   <= 5'd0;
      cmd_stb_q   <= 1'b0;
      data_stb_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cmd_stb_q  <= 1'b0;
      data_stb_q <= 1'b0;
      overrun_q  <= 1'b0;
      if (busy_q) begin
        clr_idx_q <= clr_idx_q + 5'd1;
        if (clr_idx_q == CLR_LAST) busy_q <= 1'b0;
      end
      if (sync_commit) begin
        if (busy_q) begin
          overrun_q <= 1'b1;
        end else if (sync_rs) begin
          data_stb_q <= 1'b1;
          if (!cg_sel_q) ac_q <= ac_step(ac_q, inc_mode_q);
        end else begin
          cmd_stb_q <= 1'b1;
          unique case (decode_cmd(sync_d))
            CmdClr: begin
              ac_q       <= 7'h00;
              inc_mode_q <= 1'b1;
              cg_sel_q   <= 1'b0;
              busy_q     <= 1'b1;
              clr_idx_q  <= 5'd0;
            end
            CmdHome: begin
              ac_q     <= 7'h00;
              cg_sel_q <= 1'b0;
            end
            CmdEntry: inc_mode_q <= sync_d[1];
            CmdDctl: begin
              disp_on_q   <= sync_d[2];
              cursor_on_q <= sync_d[1];
              blink_on_q  <= sync_d[0];
            end
            CmdShift: begin
              if (!sync_d[3]) ac_q <= ac_step(ac_q, sync_d[2]);
            end
            CmdFset: begin
              if (sync_d[4]) init_done_q <= 1'b1;
            end
            CmdCgaddr: cg_sel_q <= 1'b1;
            CmdDdaddr: begin
              ac_q     <= sync_d[6:0];
              cg_sel_q <= 1'b0;
            end
            CmdNone: ;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef LCD1602_RX_BLINK_EN
  logic [23:0] blink_cnt_q;
  logic        blink_phase_q;

  always_ff @(posedge FPGA_CLK) begin
    if (!RST_N) begin
      blink_cnt_q   <= 24'd0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_HALF_PERIOD - 24'd1) begin
      blink_cnt_q   <= 24'd0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 24'd1;
    end
  end

  assign CURSOR_SHOW = disp_on_q & ac_vis & (cursor_on_q | (blink_on_q & blink_phase_q));
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_HALF_PERIOD;
  assign CURSOR_SHOW  = disp_on_q & ac_vis & cursor_on_q;
`endif

  assign RD_DATA    = rd_data_q;
  assign CURSOR     = ac_vis ? ac_idx : 5'd0;
  assign CURSOR_VIS = ac_vis;
  assign DISP_ON    = disp_on_q;
  assign CURSOR_ON  = cursor_on_q;
  assign BLINK_ON   = blink_on_q;
  assign INC_MODE   = inc_mode_q;
  assign INIT_DONE  = init_done_q;
  assign BUSY       = busy_q;
  assign CMD_STB    = cmd_stb_q;
  assign DATA_STB   = data_stb_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_lcd1602_rx.sv
// Directed bench for lcd1602_rx: bus writes, image reads and flag checks against
// hand-computed values.
module tb_lcd1602_rx;

  logic       FPGA_CLK;
  logic       RST_N;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [7:0] LCD_D;
  logic [4:0] RD_ADDR;
  logic [7:0] RD_DATA;
  logic [4:0] CURSOR;
  logic       CURSOR_VIS;
  logic       CURSOR_SHOW;
  logic       DISP_ON;
  logic       CURSOR_ON;
  logic       BLINK_ON;
  logic       INC_MODE;
  logic       INIT_DONE;
  logic       BUSY;
  logic       CMD_STB;
  logic       DATA_STB;
  logic       OVERRUN;

  lcd1602_rx dut (
    .FPGA_CLK    (FPGA_CLK),
    .RST_N       (RST_N),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .LCD_E       (LCD_E),
    .LCD_D       (LCD_D),
    .RD_ADDR     (RD_ADDR),
    .RD_DATA     (RD_DATA),
    .CURSOR      (CURSOR),
    .CURSOR_VIS  (CURSOR_VIS),
    .CURSOR_SHOW (CURSOR_SHOW),
    .DISP_ON     (DISP_ON),
    .CURSOR_ON   (CURSOR_ON),
    .BLINK_ON    (BLINK_ON),
    .INC_MODE    (INC_MODE),
    .INIT_DONE   (INIT_DONE),
    .BUSY        (BUSY),
    .CMD_STB     (CMD_STB),
    .DATA_STB    (DATA_STB),
    .OVERRUN     (OVERRUN)
  );

  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  int n_checks = 0;
  int n_errors = 0;
  int n_cmd    = 0;
  int n_data   = 0;
  int n_ovr    = 0;

  always @(negedge FPGA_CLK) begin
    if (CMD_STB === 1'b1)  n_cmd  <= n_cmd + 1;
    if (DATA_STB === 1'b1) n_data <= n_data + 1;
    if (OVERRUN === 1'b1)  n_ovr  <= n_ovr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    LCD_RS = rs;
    LCD_D  = d;
    LCD_RW = 1'b0;
    LCD_E  = 1'b1;
    repeat (6) @(negedge FPGA_CLK);
    LCD_E = 1'b0;
    repeat (8) @(negedge FPGA_CLK);
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [7:0] exp);
    RD_ADDR = addr;
    @(negedge FPGA_CLK);
    @(negedge FPGA_CLK);
    check(tag, {24'd0, RD_DATA}, {24'd0, exp});
  endtask

  task automatic check_all_space(input string tag);
    for (int i = 0; i < 32; i++) read_check(tag, 5'(i), 8'h20);
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 200) begin
      @(negedge FPGA_CLK);
      n++;
    end
    check("busy_timeout", {31'd0, n < 200}, 32'd1);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      n++;
      @(negedge FPGA_CLK);
    end
    check(tag, n, 32'd32);
  endtask

  string msg = "HELLO WORLD!";
  int c0, d0, o0;

  initial begin
    RST_N   = 1'b0;
    LCD_RS  = 1'b0;
    LCD_RW  = 1'b0;
    LCD_E   = 1'b0;
    LCD_D   = 8'h00;
    RD_ADDR = 5'd0;
    repeat (3) @(negedge FPGA_CLK);

    // Reset values
    check("rst_rd_data", {24'd0, RD_DATA}, 32'h00);
    check("rst_disp_on", {31'd0, DISP_ON}, 32'd0);
    check("rst_inc_mode", {31'd0, INC_MODE}, 32'd1);
    check("rst_init_done", {31'd0, INIT_DONE}, 32'd0);
    check("rst_cursor", {27'd0, CURSOR}, 32'd0);
    check("rst_cmd_stb", {31'd0, CMD_STB}, 32'd0);

    RST_N = 1'b1;
    count_busy("rst_busy_len");
    check_all_space("rst_img");
    check("init_done_low", {31'd0, INIT_DONE}, 32'd0);

    // Init sequence and text
    c0 = n_cmd;
    bus_write(1'b0, 8'h30);
    bus_write(1'b0, 8'h0C);
    bus_write(1'b0, 8'h06);
    bus_write(1'b0, 8'h01);
    wait_not_busy();
    check("init_cmd_cnt", n_cmd - c0, 32'd4);
    d0 = n_data;
    for (int i = 0; i < 12; i++) bus_write(1'b1, msg[i]);
    check("text_data_cnt", n_data - d0, 32'd12);
    for (int i = 0; i < 12; i++) read_check("text_img", 5'(i), msg[i]);
    read_check("text_img12", 5'd12, 8'h20);
    check("text_cursor", {27'd0, CURSOR}, 32'd12);
    check("text_vis", {31'd0, CURSOR_VIS}, 32'd1);
    check("text_disp_on", {31'd0, DISP_ON}, 32'd1);
    check("text_cursor_on", {31'd0, CURSOR_ON}, 32'd0);
    check("text_init_done", {31'd0, INIT_DONE}, 32'd1);
    check("text_show_off", {31'd0, CURSOR_SHOW}, 32'd0);
    bus_write(1'b0, 8'h0E);
    check("dctl_cursor_on", {31'd0, CURSOR_ON}, 32'd1);
    check("dctl_show_on", {31'd0, CURSOR_SHOW}, 32'd1);

    // Row-0 end wrap to row 1
    bus_write(1'b0, 8'hA7);
    check("a7_vis", {31'd0, CURSOR_VIS}, 32'd0);
    check("a7_cursor", {27'd0, CURSOR}, 32'd0);
    check("a7_show", {31'd0, CURSOR_SHOW}, 32'd0);
    bus_write(1'b1, 8'h41);
    bus_write(1'b1, 8'h42);
    read_check("wrap_b16", 5'd16, 8'h42);
    read_check("wrap_15", 5'd15, 8'h20);
    check("wrap_cursor", {27'd0, CURSOR}, 32'd17);

    // Decrement mode and 0x00 -> 0x67 wrap
    bus_write(1'b0, 8'h04);
    check("entry_dec", {31'd0, INC_MODE}, 32'd0);
    bus_write(1'b0, 8'h80);
    bus_write(1'b1, 8'h58);
    read_check("dec_x0", 5'd0, 8'h58);
    check("dec_vis", {31'd0, CURSOR_VIS}, 32'd0);
    check("dec_cursor", {27'd0, CURSOR}, 32'd0);

    // Cursor shifts: 0x67 -> 0x00 -> 0x67, display shift ignored, 0x40 -> 0x27
    bus_write(1'b0, 8'h14);
    check("shr_vis", {31'd0, CURSOR_VIS}, 32'd1);
    check("shr_cursor", {27'd0, CURSOR}, 32'd0);
    bus_write(1'b0, 8'h10);
    check("shl_vis", {31'd0, CURSOR_VIS}, 32'd0);
    bus_write(1'b0, 8'h1C);
    check("dshift_vis", {31'd0, CURSOR_VIS}, 32'd0);
    bus_write(1'b0, 8'hC0);
    check("c0_cursor", {27'd0, CURSOR}, 32'd16);
    bus_write(1'b0, 8'h10);
    check("shl40_vis", {31'd0, CURSOR_VIS}, 32'd0);

    // Clear followed by a data write while busy
    c0 = n_cmd;
    d0 = n_data;
    o0 = n_ovr;
    LCD_RS = 1'b0;
    LCD_D  = 8'h01;
    LCD_RW = 1'b0;
    LCD_E  = 1'b1;
    repeat (6) @(negedge FPGA_CLK);
    LCD_E = 1'b0;
    repeat (5) @(negedge FPGA_CLK);
    LCD_RS = 1'b1;
    LCD_D  = 8'h51;
    LCD_E  = 1'b1;
    repeat (5) @(negedge FPGA_CLK);
    LCD_E = 1'b0;
    repeat (8) @(negedge FPGA_CLK);
    check("ovr_busy", {31'd0, BUSY}, 32'd1);
    wait_not_busy();
    check("ovr_cnt", n_ovr - o0, 32'd1);
    check("ovr_no_data", n_data - d0, 32'd0);
    check("ovr_cmd_cnt", n_cmd - c0, 32'd1);
    check("ovr_cursor", {27'd0, CURSOR}, 32'd0);
    check("ovr_inc_mode", {31'd0, INC_MODE}, 32'd1);
    check_all_space("ovr_img");

    // Read cycle is ignored, even carrying a clear opcode
    c0 = n_cmd;
    d0 = n_data;
    o0 = n_ovr;
    LCD_RS = 1'b0;
    LCD_D  = 8'h01;
    LCD_RW = 1'b1;
    LCD_E  = 1'b1;
    repeat (6) @(negedge FPGA_CLK);
    LCD_E = 1'b0;
    repeat (8) @(negedge FPGA_CLK);
    LCD_RW = 1'b0;
    check("rw_busy", {31'd0, BUSY}, 32'd0);
    check("rw_strobes", (n_cmd - c0) + (n_data - d0) + (n_ovr - o0), 32'd0);

    // CGRAM-addressed data is discarded; DDRAM set re-enables the image
    bus_write(1'b0, 8'h40);
    bus_write(1'b1, 8'h5A);
    read_check("cg_img0", 5'd0, 8'h20);
    check("cg_cursor", {27'd0, CURSOR}, 32'd0);
    check("cg_data_cnt", n_data - d0, 32'd1);
    bus_write(1'b0, 8'h80);
    bus_write(1'b1, 8'h4B);
    read_check("dd_img0", 5'd0, 8'h4B);
    check("dd_cursor", {27'd0, CURSOR}, 32'd1);

    // Reset in the middle of the clear sweep restarts it
    RST_N = 1'b0;
    @(negedge FPGA_CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge FPGA_CLK);
    RST_N = 1'b0;
    @(negedge FPGA_CLK);
    RST_N = 1'b1;
    count_busy("midclr_busy_len");
    read_check("midclr_img0", 5'd0, 8'h20);
    check("midclr_disp_on", {31'd0, DISP_ON}, 32'd0);
    check("midclr_init_done", {31'd0, INIT_DONE}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
